// File: rtl/mpdmac_pkg.sv
// mpdmac_pkg: shared AXI constants and FSM state types for the DMAC SRAM slave
package mpdmac_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
endpackage

// File: rtl/mpdmac_sram_bank.sv
// mpdmac_sram_bank: word array with registered read port and byte-enabled write port
module mpdmac_sram_bank #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [31:0]           o_rdata,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb
);
    logic [31:0] r_mem [2**DEPTH_LOG2];
    logic [31:0] r_rdata;
    // Registered read; a same-cycle write to the same word is seen only by later reads
    always_ff @(posedge clk) begin
        if (i_re) r_rdata <= r_mem[i_raddr];
    end
    // Byte-lane writes
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (i_we && i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/mpdmac_axi_sram_slave.sv
// mpdmac_axi_sram_slave: AXI3 INCR-burst slave backed by an internal SRAM bank
module mpdmac_axi_sram_slave
    import mpdmac_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  awid_i,
    input  logic [31:0] awaddr_i,
    input  logic [3:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [3:0]  wid_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [3:0]  bid_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i,
    input  logic [3:0]  arid_i,
    input  logic [31:0] araddr_i,
    input  logic [3:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [3:0]  rid_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rlast_o,
    output logic        rvalid_o,
    input  logic        rready_i
);
    localparam int AW = DEPTH_LOG2 + 1;
    rd_state_t r_rstate, w_rstate_nxt;
    wr_state_t r_wstate, w_wstate_nxt;
    logic [3:0]            r_rid, r_wid;
    logic [AW-1:0]         r_raddr, r_waddr;
    logic                  r_rhi, r_whi, r_rattr, r_wattr, r_wslv;
    logic [4:0]            r_rcnt, r_wcnt;
    logic [31:0]           w_ar_off, w_aw_off, w_bank_rdata;
    logic                  w_ar_hi, w_aw_hi, w_ar_attr, w_aw_attr;
    logic                  w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_r_oor, w_w_oor;
    logic [AW-1:0]         w_raddr_inc;
    logic                  w_bank_re, w_bank_we;
    logic [DEPTH_LOG2-1:0] w_bank_raddr;
    logic                  w_unused;
    assign w_unused    = &{1'b0, wid_i};
    assign w_ar_off    = araddr_i - BASE_ADDR;
    assign w_aw_off    = awaddr_i - BASE_ADDR;
    assign w_ar_hi     = (araddr_i < BASE_ADDR) || (|w_ar_off[31:DEPTH_LOG2+3]);
    assign w_aw_hi     = (awaddr_i < BASE_ADDR) || (|w_aw_off[31:DEPTH_LOG2+3]);
    assign w_ar_attr   = (arsize_i != SIZE_4B) || (arburst_i != BURST_INCR) || (w_ar_off[1:0] != 2'b00);
    assign w_aw_attr   = (awsize_i != SIZE_4B) || (awburst_i != BURST_INCR) || (w_aw_off[1:0] != 2'b00);
    assign w_ar_hs     = arvalid_i && arready_o;
    assign w_r_hs      = rvalid_o && rready_i;
    assign w_aw_hs     = awvalid_i && awready_o;
    assign w_w_hs      = wvalid_i && wready_o;
    assign w_r_oor     = r_rhi || r_raddr[AW-1];
    assign w_w_oor     = r_whi || r_waddr[AW-1];
    assign w_raddr_inc = r_raddr + 1'b1;
    assign w_bank_we   = w_w_hs && !r_wattr && !w_w_oor;
    // Both FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate <= R_IDLE;
            r_wstate <= W_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_wstate <= w_wstate_nxt;
        end
    end
    // Read FSM: prefetch the next word on every accepted beat so bursts stream at full rate
    always_comb begin
        w_rstate_nxt = r_rstate;
        arready_o    = 1'b0;
        rvalid_o     = 1'b0;
        w_bank_re    = 1'b0;
        w_bank_raddr = w_ar_off[DEPTH_LOG2+1:2];
        case (r_rstate)
            R_IDLE: begin
                arready_o = 1'b1;
                if (arvalid_i) begin
                    w_rstate_nxt = R_DATA;
                    w_bank_re    = 1'b1;
                end
            end
            default: begin
                rvalid_o = 1'b1;
                if (rready_i) begin
                    w_rstate_nxt = (r_rcnt == 5'd1) ? R_IDLE : R_DATA;
                    w_bank_re    = (r_rcnt != 5'd1);
                    w_bank_raddr = w_raddr_inc[DEPTH_LOG2-1:0];
                end
            end
        endcase
    end
    // Write FSM: address, data, then response
    always_comb begin
        w_wstate_nxt = r_wstate;
        awready_o    = 1'b0;
        wready_o     = 1'b0;
        bvalid_o     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                awready_o = 1'b1;
                if (awvalid_i) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                wready_o = 1'b1;
                if (wvalid_i && r_wcnt == 5'd1) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end
    // Read burst bookkeeping; r_rhi goes sticky once the address passes the top of the index range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rid   <= '0;
            r_raddr <= '0;
            r_rhi   <= 1'b0;
            r_rcnt  <= '0;
            r_rattr <= 1'b0;
        end else if (w_ar_hs) begin
            r_rid   <= arid_i;
            r_raddr <= w_ar_off[DEPTH_LOG2+2:2];
            r_rhi   <= w_ar_hi;
            r_rcnt  <= {1'b0, arlen_i} + 5'd1;
            r_rattr <= w_ar_attr;
        end else if (w_r_hs) begin
            r_raddr <= w_raddr_inc;
            r_rhi   <= r_rhi | (&r_raddr);
            r_rcnt  <= r_rcnt - 5'd1;
        end
    end
    // Write burst bookkeeping; r_wattr blocks all writes, r_wslv collects any reason for SLVERR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wid   <= '0;
            r_waddr <= '0;
            r_whi   <= 1'b0;
            r_wcnt  <= '0;
            r_wattr <= 1'b0;
            r_wslv  <= 1'b0;
        end else if (w_aw_hs) begin
            r_wid   <= awid_i;
            r_waddr <= w_aw_off[DEPTH_LOG2+2:2];
            r_whi   <= w_aw_hi;
            r_wcnt  <= {1'b0, awlen_i} + 5'd1;
            r_wattr <= w_aw_attr;
            r_wslv  <= w_aw_attr;
        end else if (w_w_hs) begin
            r_waddr <= r_waddr + 1'b1;
            r_whi   <= r_whi | (&r_waddr);
            r_wcnt  <= r_wcnt - 5'd1;
            r_wslv  <= r_wslv | w_w_oor | (wlast_i != (r_wcnt == 5'd1));
        end
    end
    mpdmac_sram_bank #(.DEPTH_LOG2(DEPTH_LOG2)) u_bank (
        .clk     (clk),
        .i_re    (w_bank_re),
        .i_raddr (w_bank_raddr),
        .o_rdata (w_bank_rdata),
        .i_we    (w_bank_we),
        .i_waddr (r_waddr[DEPTH_LOG2-1:0]),
        .i_wdata (wdata_i),
        .i_wstrb (wstrb_i)
    );
    assign rid_o   = r_rid;
    assign rdata_o = (rvalid_o && !w_r_oor) ? w_bank_rdata : 32'h0;
    assign rresp_o = (rvalid_o && (w_r_oor || r_rattr)) ? RESP_SLVERR : RESP_OKAY;
    assign rlast_o = rvalid_o && (r_rcnt == 5'd1);
    assign bid_o   = r_wid;
    assign bresp_o = (bvalid_o && r_wslv) ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_mpdmac_axi_sram_slave.sv
// tb_mpdmac_axi_sram_slave: directed table-driven and sequence checks of the AXI SRAM slave
module tb_mpdmac_axi_sram_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awid_i, awlen_i, wid_i, wstrb_i, bid_o, arid_i, arlen_i, rid_o;
    logic [31:0] awaddr_i, wdata_i, araddr_i, rdata_o;
    logic [2:0]  awsize_i, arsize_i;
    logic [1:0]  awburst_i, arburst_i, bresp_o, rresp_o;
    logic        awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
    logic        arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] wbuf [16];
    logic [3:0]  wstrb_g;
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic        rd_stab [16];
    logic [3:0]  rd_id [16];
    int          rd_wait [16];
    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  wsize;
        logic [1:0]  wburst;
        logic [31:0] raddr;
        logic [1:0]  exp_b;
        logic [31:0] exp_rd;
        logic [1:0]  exp_rr;
    } vec_t;
    vec_t vt [10];
    mpdmac_axi_sram_slave dut (
        .clk(clk), .rst_n(rst_n),
        .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
        .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_bound(input string nm, input int n);
        n_chk++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles", nm, n);
        end
    endtask
    task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int last_at,
                            output logic [1:0] resp, output logic [3:0] bid, output int cyc);
        int n;
        awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst; awid_i = id;
        awvalid_i = 1'b1;
        n = 0;
        while (!awready_o && n < 50) begin tick(); n++; end
        wait_bound("aw_wait", n);
        tick();
        awvalid_i = 1'b0;
        cyc = 0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata_i = wbuf[i]; wstrb_i = wstrb_g; wid_i = id; wlast_i = (i == last_at);
            wvalid_i = 1'b1;
            n = 0;
            while (!wready_o && n < 50) begin tick(); n++; cyc++; end
            if (n >= 50) wait_bound("w_wait", n);
            tick();
            cyc++;
        end
        wvalid_i = 1'b0; wlast_i = 1'b0;
        bready_i = 1'b1;
        n = 0;
        while (!bvalid_o && n < 50) begin tick(); n++; end
        wait_bound("b_wait", n);
        resp = bresp_o;
        bid = bid_o;
        tick();
        bready_i = 1'b0;
    endtask
    task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                           input logic bp);
        int n;
        araddr_i = addr; arlen_i = len; arsize_i = 3'b010; arburst_i = 2'b01; arid_i = id;
        arvalid_i = 1'b1;
        n = 0;
        while (!arready_o && n < 50) begin tick(); n++; end
        wait_bound("ar_wait", n);
        tick();
        arvalid_i = 1'b0;
        rready_i = !bp;
        for (int i = 0; i <= int'(len); i++) begin
            logic [31:0] hold;
            n = 0;
            while (!rvalid_o && n < 50) begin tick(); n++; end
            if (n >= 50) wait_bound("r_wait", n);
            rd_wait[i] = n;
            rd_stab[i] = 1'b1;
            if (bp) begin
                hold = rdata_o;
                tick();
                rd_stab[i] = rvalid_o && (rdata_o === hold);
                rready_i = 1'b1;
            end
            rd_data[i] = rdata_o; rd_resp[i] = rresp_o; rd_last[i] = rlast_o; rd_id[i] = rid_o;
            tick();
            if (bp) rready_i = 1'b0;
        end
        rready_i = 1'b0;
    endtask
    initial begin
        logic [1:0] resp;
        logic [3:0] bid;
        int cyc;
        rst_n = 1'b0;
        awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = 3'b010; awburst_i = 2'b01; awvalid_i = 1'b0;
        wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
        arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = 3'b010; arburst_i = 2'b01; arvalid_i = 1'b0;
        rready_i = 1'b0;
        wstrb_g = 4'hF;
        vt[0] = '{32'h10,   32'hDEADBEEF, 4'hF, 3'b010, 2'b01, 32'h10,   2'b00, 32'hDEADBEEF, 2'b00};
        vt[1] = '{32'h20,   32'hFFFFFFFF, 4'hF, 3'b010, 2'b01, 32'h20,   2'b00, 32'hFFFFFFFF, 2'b00};
        vt[2] = '{32'h20,   32'h12345678, 4'h5, 3'b010, 2'b01, 32'h20,   2'b00, 32'hFF34FF78, 2'b00};
        vt[3] = '{32'h20,   32'h00000000, 4'hF, 3'b010, 2'b10, 32'h20,   2'b10, 32'hFF34FF78, 2'b00};
        vt[4] = '{32'h30,   32'h11223344, 4'hF, 3'b010, 2'b01, 32'h30,   2'b00, 32'h11223344, 2'b00};
        vt[5] = '{32'h30,   32'hAAAA5555, 4'hF, 3'b001, 2'b01, 32'h30,   2'b10, 32'h11223344, 2'b00};
        vt[6] = '{32'h32,   32'h99999999, 4'hF, 3'b010, 2'b01, 32'h30,   2'b10, 32'h11223344, 2'b00};
        vt[7] = '{32'h1000, 32'h5A5A5A5A, 4'hF, 3'b010, 2'b01, 32'h1000, 2'b10, 32'h00000000, 2'b10};
        vt[8] = '{32'hFFC,  32'hCAFEF00D, 4'hF, 3'b010, 2'b01, 32'hFFC,  2'b00, 32'hCAFEF00D, 2'b00};
        vt[9] = '{32'h10,   32'h77000000, 4'h8, 3'b010, 2'b01, 32'h10,   2'b00, 32'h77ADBEEF, 2'b00};
        repeat (3) tick();
        chk("rst_awready", {31'b0, awready_o}, 32'd1);
        chk("rst_arready", {31'b0, arready_o}, 32'd1);
        chk("rst_wready", {31'b0, wready_o}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid_o}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_ids", {24'b0, rid_o, bid_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            wbuf[0] = vt[i].wdata;
            wstrb_g = vt[i].wstrb;
            do_write(vt[i].waddr, 4'd0, vt[i].wsize, vt[i].wburst, 4'(i), 0, resp, bid, cyc);
            chk($sformatf("v%0d_bresp", i), {30'b0, resp}, {30'b0, vt[i].exp_b});
            chk($sformatf("v%0d_bid", i), {28'b0, bid}, 32'(i));
            do_read(vt[i].raddr, 4'd0, 4'(15 - i), 1'b0);
            chk($sformatf("v%0d_rdata", i), rd_data[0], vt[i].exp_rd);
            chk($sformatf("v%0d_rresp", i), {30'b0, rd_resp[0]}, {30'b0, vt[i].exp_rr});
            chk($sformatf("v%0d_rlast", i), {31'b0, rd_last[0]}, 32'd1);
            chk($sformatf("v%0d_rid", i), {28'b0, rd_id[0]}, 32'(15 - i));
            chk($sformatf("v%0d_rfirst", i), rd_wait[0], 32'd0);
        end
        wstrb_g = 4'hF;
        for (int i = 0; i < 16; i++) wbuf[i] = i * 32'h11111111;
        do_write(32'h100, 4'd15, 3'b010, 2'b01, 4'hA, 15, resp, bid, cyc);
        chk("b16_cycles", cyc, 32'd16);
        chk("b16_bresp", {30'b0, resp}, 32'd0);
        chk("b16_bid", {28'b0, bid}, 32'hA);
        chk("b16_single_b", {31'b0, bvalid_o}, 32'd0);
        do_read(32'h100, 4'd15, 4'h6, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("r16_data%0d", i), rd_data[i], i * 32'h11111111);
            chk($sformatf("r16_last%0d", i), {31'b0, rd_last[i]}, {31'b0, i == 15});
            chk($sformatf("r16_gap%0d", i), rd_wait[i], 32'd0);
        end
        do_read(32'h100, 4'd15, 4'h7, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("bp_data%0d", i), rd_data[i], i * 32'h11111111);
            chk($sformatf("bp_stable%0d", i), {31'b0, rd_stab[i]}, 32'd1);
        end
        chk("bp_last", {31'b0, rd_last[15]}, 32'd1);
        do_read(32'hFFC, 4'd3, 4'h2, 1'b0);
        chk("top_d0", rd_data[0], 32'hCAFEF00D);
        chk("top_r0", {30'b0, rd_resp[0]}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("top_d%0d", i), rd_data[i], 32'd0);
            chk($sformatf("top_r%0d", i), {30'b0, rd_resp[i]}, 32'd2);
        end
        chk("top_l2", {31'b0, rd_last[2]}, 32'd0);
        chk("top_l3", {31'b0, rd_last[3]}, 32'd1);
        wbuf[0] = 32'h0BADF00D;
        do_write(32'h1FC, 4'd0, 3'b010, 2'b01, 4'h1, 0, resp, bid, cyc);
        wbuf[0] = 32'h01010101;
        do_write(32'h200, 4'd0, 3'b010, 2'b01, 4'h1, 0, resp, bid, cyc);
        araddr_i = 32'h1FC; arlen_i = 4'd1; arid_i = 4'h5; arvalid_i = 1'b1;
        awaddr_i = 32'h200; awlen_i = 4'd0; awsize_i = 3'b010; awburst_i = 2'b01; awid_i = 4'h9; awvalid_i = 1'b1;
        wdata_i = 32'hFEEDFACE; wstrb_i = 4'hF; wlast_i = 1'b1; wvalid_i = 1'b1;
        rready_i = 1'b1; bready_i = 1'b1;
        tick();
        arvalid_i = 1'b0; awvalid_i = 1'b0;
        chk("col_rvalid0", {31'b0, rvalid_o}, 32'd1);
        chk("col_d0", rdata_o, 32'h0BADF00D);
        chk("col_wready", {31'b0, wready_o}, 32'd1);
        tick();
        wvalid_i = 1'b0; wlast_i = 1'b0;
        chk("col_d1_old", rdata_o, 32'h01010101);
        chk("col_l1", {31'b0, rlast_o}, 32'd1);
        chk("col_bvalid", {31'b0, bvalid_o}, 32'd1);
        chk("col_bresp", {30'b0, bresp_o}, 32'd0);
        tick();
        rready_i = 1'b0; bready_i = 1'b0;
        chk("col_rdone", {31'b0, rvalid_o}, 32'd0);
        chk("col_arready", {31'b0, arready_o}, 32'd1);
        chk("col_bdone", {31'b0, bvalid_o}, 32'd0);
        do_read(32'h200, 4'd0, 4'h3, 1'b0);
        chk("col_new", rd_data[0], 32'hFEEDFACE);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h30303030 + i;
        do_write(32'h300, 4'd3, 3'b010, 2'b01, 4'h3, 1, resp, bid, cyc);
        chk("wl_beats", cyc, 32'd4);
        chk("wl_bresp", {30'b0, resp}, 32'd2);
        do_read(32'h30C, 4'd0, 4'h0, 1'b0);
        chk("wl_data", rd_data[0], 32'h30303033);
        araddr_i = 32'h100; arlen_i = 4'd15; arid_i = 4'h4; arvalid_i = 1'b1;
        tick();
        arvalid_i = 1'b0;
        rready_i = 1'b1;
        tick();
        tick();
        chk("rst_mid_d2", rdata_o, 32'h22222222);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rvalid", {31'b0, rvalid_o}, 32'd0);
        chk("rst_mid_arready", {31'b0, arready_o}, 32'd1);
        rready_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_read(32'h104, 4'd0, 4'h8, 1'b0);
        chk("post_rst_data", rd_data[0], 32'h11111111);
        chk("post_rst_resp", {30'b0, rd_resp[0]}, 32'd0);
        chk("post_rst_first", rd_wait[0], 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
